axis_packet_arbiter: RTL and testbench
======================================

// Module: axis_packet_arbiter
// PURPOSE
//  Packet-level round-robin arbiter that shares the single AXI-Stream ingress of
//  the stream FIFO between NUM_SRC AXI-Stream sources. The grant is held from
//  the first beat to the tlast beat, so packets never interleave.
//  Sits between the stream producers and the FIFO s_axis_* port. src_en comes
//  from AXI-Lite control bits.
// PARAMETERS
//  NUM_SRC     4    number of requesting stream sources (2..8)
//  DATA_WIDTH  32   tdata width, matches FIFO DATA_WIDTH
//  MAX_BEATS   256  max beats per grant before forced release (>=2)
// PORTS
//  ACLK       in   1                  clock, all logic on rising edge
//  ARESETn    in   1                  reset, asynchronous, active-low
//  s_tdata    in   NUM_SRC*DATA_WIDTH source i data at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_tvalid   in   NUM_SRC            per-source valid
//  s_tlast    in   NUM_SRC            per-source end-of-packet
//  s_tready   out  NUM_SRC            per-source ready
//  src_en     in   NUM_SRC            1 = source eligible for new grants
//  m_tdata    out  DATA_WIDTH         to FIFO s_axis_tdata
//  m_tvalid   out  1                  to FIFO s_axis_tvalid
//  m_tlast    out  1                  to FIFO s_axis_tlast
//  m_tready   in   1                  from FIFO s_axis_tready
//  grant_id   out  $clog2(NUM_SRC)    index of current or last granted source
//  busy       out  1                  1 while in LOCK
//  pkt_done   out  1                  1-cycle pulse after a granted packet ends
//  trunc_err  out  1                  1-cycle pulse after a MAX_BEATS forced release
// BEHAVIOUR
//  - Reset: FSM=IDLE, m_tvalid=0, s_tready=0, busy=0, pkt_done=0, trunc_err=0,
//    grant_id=0, last_grant=NUM_SRC-1 (source 0 wins first), beat_cnt=0.
//  - Request: req[i] = s_tvalid[i] & src_en[i].
//  - IDLE: all s_tready=0, m_tvalid=0. If any req is set, pick the first
//    requesting index after last_grant, searching upward with modulo wrap.
//    Register it into grant_id, clear beat_cnt, then go to LOCK.
//    Arbitration costs exactly 1 IDLE cycle.
//  - LOCK, combinational path, g = grant_id:
//      m_tdata  = s_tdata[g]
//      m_tvalid = s_tvalid[g]
//      s_tready[g] = m_tready; all other s_tready = 0
//      m_tlast = s_tlast[g] | (beat_cnt == MAX_BEATS-1)
//  - Beat: m_tvalid & m_tready. On each beat, beat_cnt increments.
//  - On the beat where m_tlast=1, on the next edge: go to IDLE, last_grant <= g,
//    and pulse pkt_done. If s_tlast[g]=0 on that beat, also pulse trunc_err.
//    The rest of the source's data arbitrates later as a new packet.
//  - src_en deasserting for g during LOCK has no effect until the packet ends.
//    An idle, non-requesting source never blocks others, because it is never
//    granted.
//  - s_tvalid[g] dropping mid-packet: hold LOCK. This is legal AXIS
//    backpressure on the source side.
//  - m_tready=0 (FIFO full): hold state, no beat. m_tdata and m_tlast follow
//    the source, which must hold them stable per AXIS rules.
//  - beat_cnt width is $clog2(MAX_BEATS)+1 and must not wrap within a grant.
//  - Reset mid-packet: immediate return to reset values. The partial packet is
//    already in the FIFO; clearing it is software's job via the FIFO reset bit.
//  - grant_id holds its value in IDLE until the next grant.
// TESTING
//  1 Single source 0, 4-beat pkt, m_tready=1 -> 1 IDLE cycle, then 4 beats
//    in order, m_tlast on beat 4, pkt_done 1 cycle later, grant_id=0.
//  2 All 4 sources request 2-beat pkts continuously -> grant order 0,1,2,3,0;
//    no beat from a non-granted source; s_tready one-hot or zero.
//  3 Src1 mid 8-beat pkt while src0 requests, m_tready toggles 1/0 -> src1 pkt
//    contiguous, 8 beats, then src0 granted; data ordered under stalls.
//  4 MAX_BEATS=4, src2 sends 6 beats with tlast on beat 6 -> beat 4 m_tlast=1,
//    trunc_err pulse; after others' turns, src2 sends 2 beats with tlast.
//  5 src_en=4'b1011, src2 requesting -> src2 never granted. Clear src_en[1]
//    mid src1 pkt -> src1 pkt completes.
//  6 ARESETn low during beat 3 of a pkt -> all outputs at reset values
//    asynchronously; after release, src0 wins first.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter feeding one AXI-Stream sink from NUM_SRC sources.
// A grant is held from first beat to tlast (or a forced release after MAX_BEATS beats).
module axis_packet_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic [NUM_SRC-1:0]            s_tready,
    input  logic [NUM_SRC-1:0]            src_en,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy,
    output logic                          pkt_done,
    output logic                          trunc_err
);
    localparam int GW = $clog2(NUM_SRC);
    localparam int CW = $clog2(MAX_BEATS) + 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       grant_q, grant_nxt, last_q, last_nxt, pick;
    logic [CW-1:0]       beat_cnt, beat_cnt_nxt;
    logic                pkt_done_nxt, trunc_nxt, any_req;
    logic [NUM_SRC-1:0]  req;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                sel_valid, sel_last, cnt_max;

    assign req      = s_tvalid & src_en;
    assign grant_id = grant_q;
    assign cnt_max  = (beat_cnt == CW'(MAX_BEATS - 1));

    // Round-robin search: first requester strictly after last_q, wrapping.
    always_comb begin
        logic [GW-1:0] idx;
        pick    = last_q;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = GW'((32'(last_q) + k) % 32'(NUM_SRC));
            if (!any_req && req[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_q;
        last_nxt     = last_q;
        beat_cnt_nxt = beat_cnt;
        pkt_done_nxt = 1'b0;
        trunc_nxt    = 1'b0;
        m_tdata      = sel_data;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        s_tready     = '0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt    = pick;
                    beat_cnt_nxt = '0;
                    state_nxt    = LOCK;
                end
            end
            LOCK: begin
                busy     = 1'b1;
                m_tvalid = sel_valid;
                m_tlast  = sel_last | cnt_max;
                for (int unsigned i = 0; i < NUM_SRC; i++)
                    s_tready[i] = (grant_q == GW'(i)) & m_tready;
                if (sel_valid && m_tready) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    // Forced release ends the grant even without source tlast.
                    if (sel_last || cnt_max) begin
                        state_nxt    = IDLE;
                        last_nxt     = grant_q;
                        pkt_done_nxt = 1'b1;
                        trunc_nxt    = ~sel_last;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NUM_SRC - 1);
            beat_cnt  <= '0;
            pkt_done  <= 1'b0;
            trunc_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            last_q    <= last_nxt;
            beat_cnt  <= beat_cnt_nxt;
            pkt_done  <= pkt_done_nxt;
            trunc_err <= trunc_nxt;
        end
    end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: queued source models, beat logger, expected tables.
module tb_axis_packet_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid, s_tlast, src_en;
    logic            m_tready;

    logic [N-1:0]  a_s_tready, b_s_tready, o_s_tready;
    logic [DW-1:0] a_m_tdata, b_m_tdata, o_m_tdata;
    logic          a_m_tvalid, b_m_tvalid, o_m_tvalid;
    logic          a_m_tlast, b_m_tlast, o_m_tlast;
    logic [1:0]    a_grant_id, b_grant_id, o_grant_id;
    logic          a_busy, b_busy, o_busy;
    logic          a_pkt_done, b_pkt_done, o_pkt_done;
    logic          a_trunc_err, b_trunc_err, o_trunc_err;

    axis_packet_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .MAX_BEATS(256)) dut_a (
        .ACLK(ACLK), .ARESETn(ARESETn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(a_s_tready), .src_en(src_en), .m_tdata(a_m_tdata),
        .m_tvalid(a_m_tvalid), .m_tlast(a_m_tlast), .m_tready(m_tready),
        .grant_id(a_grant_id), .busy(a_busy), .pkt_done(a_pkt_done), .trunc_err(a_trunc_err));

    axis_packet_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .MAX_BEATS(4)) dut_b (
        .ACLK(ACLK), .ARESETn(ARESETn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(b_s_tready), .src_en(src_en), .m_tdata(b_m_tdata),
        .m_tvalid(b_m_tvalid), .m_tlast(b_m_tlast), .m_tready(m_tready),
        .grant_id(b_grant_id), .busy(b_busy), .pkt_done(b_pkt_done), .trunc_err(b_trunc_err));

    logic sel, toggle, flush;

    always_comb begin
        if (sel) begin
            o_s_tready = b_s_tready; o_m_tdata = b_m_tdata; o_m_tvalid = b_m_tvalid;
            o_m_tlast = b_m_tlast; o_grant_id = b_grant_id; o_busy = b_busy;
            o_pkt_done = b_pkt_done; o_trunc_err = b_trunc_err;
        end else begin
            o_s_tready = a_s_tready; o_m_tdata = a_m_tdata; o_m_tvalid = a_m_tvalid;
            o_m_tlast = a_m_tlast; o_grant_id = a_grant_id; o_busy = a_busy;
            o_pkt_done = a_pkt_done; o_trunc_err = a_trunc_err;
        end
    end

    // Source models: per-source beat queues, popped on handshake with the selected DUT.
    logic [31:0] mem   [N][64];
    logic        lastm [N][64];
    int          head [N];
    int          tail [N];

    always_comb begin
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]          = head[i] < tail[i];
            s_tdata[i*DW +: DW]  = mem[i][head[i]];
            s_tlast[i]           = lastm[i][head[i]];
        end
    end

    always @(posedge ACLK) begin
        for (int i = 0; i < N; i++) begin
            if (flush) head[i] <= tail[i];
            else if (s_tvalid[i] && o_s_tready[i]) head[i] <= head[i] + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bw(input int src, input int tag, input int beat);
        return {8'(src), 8'(tag), 16'(beat)};
    endfunction

    logic [31:0] log_data [$];
    logic        log_last [$];
    int          n_done = 0;
    int          n_trunc = 0;

    always @(negedge ACLK) begin
        if (ARESETn) begin
            check("tready_onehot0", 32'($onehot0(o_s_tready)), 32'd1);
            if (o_m_tvalid && m_tready) begin
                check("beat_src", 32'(o_m_tdata[31:24]), 32'(o_grant_id));
                log_data.push_back(o_m_tdata);
                log_last.push_back(o_m_tlast);
            end
            if (o_pkt_done)  n_done++;
            if (o_trunc_err) n_trunc++;
        end
    end

    logic [31:0] exp_d [$];
    logic        exp_l [$];

    task automatic push_pkt(input int src, input int tag, input int n);
        for (int b = 0; b < n; b++) begin
            mem[src][tail[src]]   = bw(src, tag, b);
            lastm[src][tail[src]] = (b == n - 1);
            tail[src]++;
        end
    endtask

    task automatic expect_beats(input int src, input int tag, input int first, input int cnt,
                                input logic last_at_end);
        for (int b = first; b < first + cnt; b++) begin
            exp_d.push_back(bw(src, tag, b));
            exp_l.push_back(last_at_end && (b == first + cnt - 1));
        end
    endtask

    task automatic check_log(input int base);
        check("log_len", 32'(log_data.size() - base), 32'(exp_d.size()));
        for (int k = 0; k < exp_d.size(); k++) begin
            if (base + k < log_data.size()) begin
                check("beat_data", log_data[base + k], exp_d[k]);
                check("beat_last", 32'(log_last[base + k]), 32'(exp_l[k]));
            end
        end
        exp_d = {};
        exp_l = {};
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge ACLK); #1;
            if (toggle) m_tready = ~m_tready;
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int c = 0;
        while (log_data.size() < n && c < budget) begin
            wait_cycles(1);
            c++;
        end
        check("wait_beats", 32'(log_data.size() >= n), 32'd1);
    endtask

    task automatic wait_grant(input int g, input int budget);
        int c = 0;
        while (!(o_busy && o_grant_id == 2'(g)) && c < budget) begin
            wait_cycles(1);
            c++;
        end
        check("wait_grant", 32'(o_busy && o_grant_id == 2'(g)), 32'd1);
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        wait_cycles(2);
        ARESETn = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},   32'(o_busy), 32'd0);
        check({tag, "_tvalid"}, 32'(o_m_tvalid), 32'd0);
        check({tag, "_tlast"},  32'(o_m_tlast), 32'd0);
        check({tag, "_tready"}, 32'(o_s_tready), 32'd0);
        check({tag, "_grant"},  32'(o_grant_id), 32'd0);
        check({tag, "_done"},   32'(o_pkt_done), 32'd0);
        check({tag, "_trunc"},  32'(o_trunc_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, d0, t0;
        ARESETn  = 1'b0;
        m_tready = 1'b1;
        src_en   = '1;
        sel      = 1'b0;
        toggle   = 1'b0;
        flush    = 1'b0;
        @(negedge ACLK);
        check_reset_vals("rst");
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        wait_cycles(2);

        // 1: single 4-beat packet from source 0, cycle-exact
        push_pkt(0, 16, 4);
        @(negedge ACLK);
        check("t1_idle_busy", 32'(o_busy), 32'd0);
        check("t1_idle_valid", 32'(o_m_tvalid), 32'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge ACLK);
            check("t1_valid", 32'(o_m_tvalid), 32'd1);
            check("t1_data", o_m_tdata, bw(0, 16, b));
            check("t1_last", 32'(o_m_tlast), 32'(b == 3));
            check("t1_tready", 32'(o_s_tready), 32'h1);
        end
        @(negedge ACLK);
        check("t1_done", 32'(o_pkt_done), 32'd1);
        check("t1_busy_end", 32'(o_busy), 32'd0);
        check("t1_grant", 32'(o_grant_id), 32'd0);
        @(negedge ACLK);
        check("t1_done_pulse", 32'(o_pkt_done), 32'd0);
        @(posedge ACLK); #1;

        // 2: all sources, two 2-beat packets each -> 0,1,2,3,0,1,2,3
        do_reset();
        base = log_data.size();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) push_pkt(s, 32 + r, 2);
        wait_beats(base + 16, 200);
        wait_cycles(3);
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) expect_beats(s, 32 + r, 0, 2, 1'b1);
        check_log(base);

        // 3: src1 8-beat packet under stalls, src0 arrives mid-packet
        base = log_data.size();
        push_pkt(1, 48, 8);
        toggle = 1'b1;
        wait_grant(1, 20);
        push_pkt(0, 49, 4);
        wait_beats(base + 12, 300);
        toggle = 1'b0;
        m_tready = 1'b1;
        wait_cycles(3);
        expect_beats(1, 48, 0, 8, 1'b1);
        expect_beats(0, 49, 0, 4, 1'b1);
        check_log(base);

        // 4: MAX_BEATS=4 instance, 6-beat packet gets split
        sel = 1'b1;
        do_reset();
        base = log_data.size();
        d0 = n_done;
        t0 = n_trunc;
        push_pkt(2, 64, 6);
        wait_grant(2, 20);
        push_pkt(3, 65, 2);
        push_pkt(0, 66, 2);
        wait_beats(base + 10, 200);
        wait_cycles(3);
        expect_beats(2, 64, 0, 4, 1'b1);
        expect_beats(3, 65, 0, 2, 1'b1);
        expect_beats(0, 66, 0, 2, 1'b1);
        expect_beats(2, 64, 4, 2, 1'b1);
        check_log(base);
        check("t4_trunc_cnt", 32'(n_trunc - t0), 32'd1);
        check("t4_done_cnt", 32'(n_done - d0), 32'd4);

        // 5: disabled src2 never granted; disabling src1 mid-packet is ignored
        base = log_data.size();
        src_en = 4'b1011;
        push_pkt(2, 80, 2);
        push_pkt(1, 81, 4);
        wait_grant(1, 20);
        src_en = 4'b1001;
        wait_beats(base + 4, 100);
        wait_cycles(10);
        expect_beats(1, 81, 0, 4, 1'b1);
        check_log(base);
        check("t5_busy", 32'(o_busy), 32'd0);
        check("t5_grant_hold", 32'(o_grant_id), 32'd1);

        // 6: asynchronous reset during beat 3, then source 0 wins first
        flush = 1'b1;
        wait_cycles(1);
        flush = 1'b0;
        src_en = '1;
        base = log_data.size();
        push_pkt(3, 96, 4);
        wait_beats(base + 2, 50);
        check("t6_beat3_valid", 32'(o_m_tvalid), 32'd1);
        ARESETn = 1'b0;
        #1;
        check_reset_vals("t6");
        flush = 1'b1;
        wait_cycles(1);
        flush = 1'b0;
        push_pkt(1, 97, 2);
        push_pkt(0, 98, 2);
        wait_cycles(1);
        ARESETn = 1'b1;
        base = log_data.size();
        wait_beats(base + 4, 50);
        wait_cycles(3);
        expect_beats(0, 98, 0, 2, 1'b1);
        expect_beats(1, 97, 0, 2, 1'b1);
        check_log(base);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
